// File: rtl/fft_power_reorder.sv
// Converts the bit-reversed complex FFT output stream to per-bin power and
// replays the non-redundant bins 0..N_FFT/2 in natural order, one per cycle.
module fft_power_reorder #(
    parameter int IN_WIDTH  = 13,
    parameter int OUT_WIDTH = 16,
    parameter int PWR_SHIFT = 8,
    parameter int N_FFT     = 256,
    localparam int CNT_W    = $clog2(N_FFT),
    localparam int IDX_W    = $clog2(N_FFT / 2 + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        spi_en_inf_system_sync,
    input  logic                        valid_in,
    input  logic signed [IN_WIDTH-1:0]  Re_in,
    input  logic signed [IN_WIDTH-1:0]  Im_in,
    output logic                        valid_out,
    output logic [IDX_W-1:0]            bin_idx_out,
    output logic [OUT_WIDTH-1:0]        power_out,
    output logic                        frame_done,
    output logic                        overrun
);

    localparam int RAW_W = 2 * IN_WIDTH + 1;
    localparam int DEPTH = N_FFT / 2 + 1;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(N_FFT / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_FFT - 1);
    localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(N_FFT / 2);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_DRAIN   = 1'b1
    } state_t;

    function automatic logic [CNT_W-1:0] bitrev(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        r = '0;
        for (int i = 0; i < CNT_W; i++) begin
            r[i] = v[CNT_W-1-i];
        end
        return r;
    endfunction

    function automatic logic [OUT_WIDTH-1:0] sat_power(input logic [RAW_W-1:0] raw);
        logic [RAW_W-1:0] sh;
        sh = raw >> PWR_SHIFT;
        if ((sh >> OUT_WIDTH) != '0) begin
            return '1;
        end else begin
            return OUT_WIDTH'(sh);
        end
    endfunction

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_in_cnt;
    logic [OUT_WIDTH-1:0]    r_p_data;
    logic [IDX_W-1:0]        r_p_addr;
    logic                    r_p_wen;
    logic                    r_p_last;
    logic [IDX_W-1:0]        r_rd_addr;
    logic [IDX_W-1:0]        r_rd_idx;
    logic                    r_rd_valid;
    logic [OUT_WIDTH-1:0]    r_rd_data;
    logic [OUT_WIDTH-1:0]    r_buf [0:DEPTH-1];
    logic                    r_valid_out;
    logic [IDX_W-1:0]        r_bin_idx;
    logic [OUT_WIDTH-1:0]    r_power;
    logic                    r_frame_done;
    logic                    r_overrun;

    logic signed [2*IN_WIDTH-1:0] w_re_sq;
    logic signed [2*IN_WIDTH-1:0] w_im_sq;
    logic [RAW_W-1:0]             w_raw;
    logic [CNT_W-1:0]             w_rev;
    logic                         w_accept;
    logic                         w_sync;

    assign w_sync   = spi_en_inf_system_sync;
    assign w_re_sq  = Re_in * Re_in;
    assign w_im_sq  = Im_in * Im_in;
    assign w_raw    = RAW_W'($unsigned(w_re_sq)) + RAW_W'($unsigned(w_im_sq));
    assign w_rev    = bitrev(r_in_cnt);
    assign w_accept = valid_in && (r_state == ST_COLLECT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_COLLECT;
        end else if (!w_sync) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: drain starts once the last sample sits in the stage register
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_COLLECT: begin
                if (r_p_last) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_DRAIN: begin
                if (r_rd_addr == LAST_BIN) begin
                    w_state_nxt = ST_COLLECT;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: w_state_nxt = ST_COLLECT;
        endcase
    end

    // Input stage: power computation and bit-reversed write address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_cnt <= '0;
            r_p_data <= '0;
            r_p_addr <= '0;
            r_p_wen  <= 1'b0;
            r_p_last <= 1'b0;
        end else if (!w_sync) begin
            r_in_cnt <= '0;
            r_p_data <= '0;
            r_p_addr <= '0;
            r_p_wen  <= 1'b0;
            r_p_last <= 1'b0;
        end else if (w_accept) begin
            r_in_cnt <= r_in_cnt + 1'b1;
            r_p_data <= sat_power(w_raw);
            r_p_addr <= IDX_W'(w_rev);
            r_p_wen  <= (w_rev <= HALF_CNT);
            r_p_last <= (r_in_cnt == LAST_CNT);
        end else begin
            r_p_wen  <= 1'b0;
            r_p_last <= 1'b0;
        end
    end

    // Bin buffer: write port from the input stage, registered read port for the drain
    always_ff @(posedge clk) begin
        if (r_p_wen && w_sync) begin
            r_buf[r_p_addr] <= r_p_data;
        end
        r_rd_data <= r_buf[r_rd_addr];
    end

    // Drain read address and read-side valid/index tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr  <= '0;
            r_rd_idx   <= '0;
            r_rd_valid <= 1'b0;
        end else if (!w_sync) begin
            r_rd_addr  <= '0;
            r_rd_idx   <= '0;
            r_rd_valid <= 1'b0;
        end else if (r_state == ST_DRAIN) begin
            r_rd_valid <= 1'b1;
            r_rd_idx   <= r_rd_addr;
            if (r_rd_addr == LAST_BIN) begin
                r_rd_addr <= '0;
            end else begin
                r_rd_addr <= r_rd_addr + 1'b1;
            end
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_addr  <= '0;
        end
    end

    // Output registers; index and power hold while idle, overrun is sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_out  <= 1'b0;
            r_bin_idx    <= '0;
            r_power      <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (!w_sync) begin
            r_valid_out  <= 1'b0;
            r_bin_idx    <= '0;
            r_power      <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_valid_out  <= r_rd_valid;
            r_frame_done <= r_rd_valid && (r_rd_idx == LAST_BIN);
            if (r_rd_valid) begin
                r_bin_idx <= r_rd_idx;
                r_power   <= r_rd_data;
            end else begin
                r_bin_idx <= r_bin_idx;
                r_power   <= r_power;
            end
            if (valid_in && (r_state == ST_DRAIN)) begin
                r_overrun <= 1'b1;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

    assign valid_out   = r_valid_out;
    assign bin_idx_out = r_bin_idx;
    assign power_out   = r_power;
    assign frame_done  = r_frame_done;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_fft_power_reorder.sv
// Randomized bench for fft_power_reorder (N_FFT=16) against a frame-level power/reorder model.
module tb_fft_power_reorder;

    localparam int NF   = 16;
    localparam int NB   = NF / 2 + 1;
    localparam int IW   = 13;
    localparam int OW   = 16;
    localparam int SH   = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 sync_en;
    logic                 valid_in;
    logic signed [IW-1:0] re_in;
    logic signed [IW-1:0] im_in;
    logic                 valid_out;
    logic [3:0]           bin_idx_out;
    logic [OW-1:0]        power_out;
    logic                 frame_done;
    logic                 overrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_in_cyc = 0;
    int n_bins = 0;
    int n_frames = 0;
    bit prev_valid = 1'b0;
    int exp_pwr_q[$];
    int exp_bin_q[$];

    fft_power_reorder #(
        .IN_WIDTH (IW),
        .OUT_WIDTH(OW),
        .PWR_SHIFT(SH),
        .N_FFT    (NF)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .spi_en_inf_system_sync(sync_en),
        .valid_in              (valid_in),
        .Re_in                 (re_in),
        .Im_in                 (im_in),
        .valid_out             (valid_out),
        .bin_idx_out           (bin_idx_out),
        .power_out             (power_out),
        .frame_done            (frame_done),
        .overrun               (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_power(input int re, input int im);
        longint raw;
        raw = longint'(re) * re + longint'(im) * im;
        raw = raw / (longint'(1) << SH);
        if (raw > ((longint'(1) << OW) - 1)) raw = (longint'(1) << OW) - 1;
        return int'(raw);
    endfunction

    function automatic int rev_index(input int b);
        int r = 0;
        int x = b;
        for (int i = 0; i < 4; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mode 0: impulse, 1: ramp k, 2: saturation mix, 3: random
    task automatic send_frame(input int mode, input bit gapped);
        int re_a[NF];
        int im_a[NF];
        for (int k = 0; k < NF; k++) begin
            case (mode)
                0: begin re_a[k] = 4; im_a[k] = 0; end
                1: begin re_a[k] = 4 * k; im_a[k] = 0; end
                2: begin
                    if (k % 3 == 0) begin re_a[k] = -4096; im_a[k] = -4096; end
                    else if (k % 3 == 1) begin re_a[k] = 100; im_a[k] = 100; end
                    else begin re_a[k] = int'($urandom_range(0, 8191)) - 4096; im_a[k] = 4095; end
                end
                default: begin
                    re_a[k] = int'($urandom_range(0, 8191)) - 4096;
                    im_a[k] = int'($urandom_range(0, 8191)) - 4096;
                end
            endcase
            valid_in = 1'b1;
            re_in    = IW'(re_a[k]);
            im_in    = IW'(im_a[k]);
            wait_edges(1);
            if (gapped && k != NF - 1) begin
                valid_in = 1'b0;
                re_in    = IW'($urandom);
                wait_edges(1);
            end
        end
        valid_in    = 1'b0;
        last_in_cyc = cyc;
        n_frames++;
        for (int b = 0; b < NB; b++) begin
            exp_pwr_q.push_back(model_power(re_a[rev_index(b)], im_a[rev_index(b)]));
            exp_bin_q.push_back(b);
        end
    endtask

    // Output monitor: every valid bin is matched against the model queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_out) begin
                if (exp_pwr_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    int ep;
                    int eb;
                    ep = exp_pwr_q.pop_front();
                    eb = exp_bin_q.pop_front();
                    check("bin_idx", bin_idx_out, eb);
                    check("power", power_out, ep);
                    check("frame_done", frame_done, (eb == NB - 1) ? 1 : 0);
                    if (eb == 0) check("latency", cyc - last_in_cyc, 3);
                    else check("contiguous", prev_valid, 1);
                    n_bins++;
                end
            end else begin
                check("frame_done_idle", frame_done, 0);
            end
            prev_valid = valid_out;
        end
    end

    initial begin
        rst_n    = 1'b0;
        sync_en  = 1'b1;
        valid_in = 1'b0;
        re_in    = '0;
        im_in    = '0;
        wait_edges(3);
        check("rst_valid_out", valid_out, 0);
        check("rst_bin_idx", bin_idx_out, 0);
        check("rst_power", power_out, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        wait_edges(2);

        send_frame(0, 1'b0);
        wait_edges(14);
        send_frame(1, 1'b0);
        wait_edges(14);
        send_frame(2, 1'b0);
        wait_edges(14);

        // overrun: pulse valid_in while the frame is draining
        send_frame(3, 1'b0);
        wait_edges(2);
        valid_in = 1'b1;
        re_in    = IW'($urandom);
        im_in    = IW'($urandom);
        wait_edges(1);
        valid_in = 1'b0;
        check("overrun_set", overrun, 1);
        wait_edges(9);
        check("overrun_sticky", overrun, 1);
        sync_en = 1'b0;
        wait_edges(1);
        sync_en = 1'b1;
        check("overrun_cleared", overrun, 0);
        check("sync_valid_out", valid_out, 0);
        wait_edges(2);

        // gapped frame followed immediately by a back-to-back frame
        send_frame(3, 1'b1);
        wait_edges(10);
        send_frame(3, 1'b0);
        wait_edges(14);
        check("overrun_b2b", overrun, 0);

        // partial frame discarded by a one-cycle sync clear
        for (int k = 0; k < 7; k++) begin
            valid_in = 1'b1;
            re_in    = IW'($urandom);
            im_in    = IW'($urandom);
            wait_edges(1);
        end
        valid_in = 1'b0;
        sync_en  = 1'b0;
        wait_edges(1);
        sync_en  = 1'b1;
        check("midclr_valid_out", valid_out, 0);
        send_frame(3, 1'b0);

        for (int t = 0; t < 100 && exp_pwr_q.size() != 0; t++) wait_edges(1);
        wait_edges(4);
        check("queue_drained", exp_pwr_q.size(), 0);
        check("bins_total", n_bins, n_frames * NB);
        check("final_overrun", overrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
